// File: rtl/pc_pkg.sv
// Shared constants and next-PC select encoding for the fetch-stage PC controller.
package pc_pkg;

  localparam int          PC_INC           = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'd0,
    SEL_BRANCH = 2'd1,
    SEL_JUMP   = 2'd2
  } next_sel_e;

endpackage

// File: rtl/pc_next_logic.sv
// Combinational next-PC selection: sequential +4, word-offset branch, or
// region-relative absolute jump (jump has priority over branch).
module pc_next_logic
  import pc_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int JADDR_W = 26
) (
  input  logic [WIDTH-1:0]   pc,
  input  logic               beq,
  input  logic               jump,
  input  logic [WIDTH-1:0]   branch_offset,
  input  logic [JADDR_W-1:0] jump_addr,
  output logic [WIDTH-1:0]   next_pc
);

  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] branch_target;
  logic [WIDTH-1:0] jump_target;
  next_sel_e        sel;

  // Jump keeps the top bits of pc+4 so targets stay inside the current region.
  always_comb begin
    pc_plus4      = pc + WIDTH'(PC_INC);
    branch_target = pc_plus4 + (branch_offset << 2);
    jump_target   = {pc_plus4[WIDTH-1:JADDR_W+2], jump_addr, 2'b00};

    sel = SEL_SEQ;
    if (jump) begin
      sel = SEL_JUMP;
    end else if (beq) begin
      sel = SEL_BRANCH;
    end

    case (sel)
      SEL_JUMP:   next_pc = jump_target;
      SEL_BRANCH: next_pc = branch_target;
      default:    next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/pc_control_32_core.sv
// Program-counter register with start/finish handshake; one update per
// accepted start, finish acknowledges the update in the following cycle.
module pc_control_32_core
  import pc_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               JADDR_W  = 26,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               beq,
  input  logic               jump,
  input  logic [WIDTH-1:0]   branch_offset,
  input  logic [JADDR_W-1:0] jump_addr,
  output logic [WIDTH-1:0]   pc,
  output logic               finish
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             finish_q, finish_d;
  logic [WIDTH-1:0] next_pc;

  pc_next_logic #(
    .WIDTH  (WIDTH),
    .JADDR_W(JADDR_W)
  ) u_next (
    .pc           (pc_q),
    .beq          (beq),
    .jump         (jump),
    .branch_offset(branch_offset),
    .jump_addr    (jump_addr),
    .next_pc      (next_pc)
  );

  always_comb begin
    pc_d     = pc_q;
    finish_d = 1'b0;
    if (start) begin
      pc_d     = next_pc;
      finish_d = 1'b1;
    end
  end

  // Reset is active-low and asynchronous; it beats a coincident start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      finish_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      finish_q <= finish_d;
    end
  end

  assign pc     = pc_q;
  assign finish = finish_q;

endmodule

// File: tb/tb_pc_control_32_core.sv
// Self-checking bench for pc_control_32_core: directed scenarios plus a
// randomized run against an arithmetic reference model.
module tb_pc_control_32_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        beq;
  logic        jump;
  logic [31:0] branch_offset;
  logic [25:0] jump_addr;
  logic [31:0] pc;
  logic        finish;

  int checks = 0;
  int passes = 0;

  logic [31:0] m_pc;
  logic        m_finish;

  pc_control_32_core dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .beq          (beq),
    .jump         (jump),
    .branch_offset(branch_offset),
    .jump_addr    (jump_addr),
    .pc           (pc),
    .finish       (finish)
  );

  always #5 clk = ~clk;

  // Reference: plain arithmetic on the architectural rules.
  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic b,
                                             input logic j, input logic [31:0] off,
                                             input logic [25:0] ja);
    longint unsigned seq;
    seq = (longint'(cur) + 4) % 64'h1_0000_0000;
    if (j)
      return 32'((seq / 32'h1000_0000) * 32'h1000_0000 + longint'(ja) * 4);
    else if (b)
      return 32'((seq + longint'(off) * 4) % 64'h1_0000_0000);
    else
      return 32'(seq);
  endfunction

  task automatic drive(input logic s, input logic b, input logic j,
                       input logic [31:0] off, input logic [25:0] ja);
    start = s; beq = b; jump = j; branch_offset = off; jump_addr = ja;
    @(posedge clk);
    if (s) begin
      m_pc     = model_next(m_pc, b, j, off, ja);
      m_finish = 1'b1;
    end else begin
      m_finish = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; beq = 1'b0; jump = 1'b0;
    branch_offset = '0; jump_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (pc !== 32'h0) $display("[TB] FAIL reset_pc: got %h expected %h", pc, 32'h0); else passes++;
    checks++; if (finish !== 1'b0) $display("[TB] FAIL reset_finish: got %b expected 0", finish); else passes++;
    @(negedge clk);
    reset = 1'b1; m_pc = 32'h0; m_finish = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b1, 32'h5, 26'h7);
      checks++; if (pc !== 32'h0) $display("[TB] FAIL idle_pc: got %h expected %h", pc, 32'h0); else passes++;
      checks++; if (finish !== 1'b0) $display("[TB] FAIL idle_finish: got %b expected 0", finish); else passes++;
    end
  endtask

  task automatic test_sequential();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 26'h0);
    checks++; if (pc !== 32'd4) $display("[TB] FAIL seq_pc: got %h expected %h", pc, 32'd4); else passes++;
    checks++; if (finish !== 1'b1) $display("[TB] FAIL seq_finish: got %b expected 1", finish); else passes++;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 26'h0);
    checks++; if (pc !== 32'd4) $display("[TB] FAIL hold_pc: got %h expected %h", pc, 32'd4); else passes++;
    checks++; if (finish !== 1'b0) $display("[TB] FAIL hold_finish: got %b expected 0", finish); else passes++;
  endtask

  task automatic test_jump_branch();
    drive(1'b1, 1'b0, 1'b1, 32'd2000, 26'd1000);
    checks++; if (pc !== 32'd4000) $display("[TB] FAIL jump_pc: got %h expected %h", pc, 32'd4000); else passes++;
    drive(1'b1, 1'b1, 1'b0, 32'd2000, 26'd1000);
    checks++; if (pc !== 32'd12004) $display("[TB] FAIL branch_pc: got %h expected %h", pc, 32'd12004); else passes++;
    checks++; if (finish !== 1'b1) $display("[TB] FAIL b2b_finish: got %b expected 1", finish); else passes++;
  endtask

  task automatic test_priority();
    drive(1'b1, 1'b1, 1'b1, 32'd2000, 26'd1000);
    checks++; if (pc !== 32'd4000) $display("[TB] FAIL prio_pc: got %h expected %h", pc, 32'd4000); else passes++;
  endtask

  task automatic test_edges();
    drive(1'b1, 1'b0, 1'b1, 32'h0, 26'd25);
    checks++; if (pc !== 32'd100) $display("[TB] FAIL setup100_pc: got %h expected %h", pc, 32'd100); else passes++;
    drive(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 26'h0);
    checks++; if (pc !== 32'd100) $display("[TB] FAIL negoff_pc: got %h expected %h", pc, 32'd100); else passes++;
    drive(1'b1, 1'b0, 1'b1, 32'h0, 26'h0);
    checks++; if (pc !== 32'h0) $display("[TB] FAIL jump0_pc: got %h expected %h", pc, 32'h0); else passes++;
    drive(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE, 26'h0);
    checks++; if (pc !== 32'hFFFF_FFFC) $display("[TB] FAIL backwrap_pc: got %h expected %h", pc, 32'hFFFF_FFFC); else passes++;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 26'h0);
    checks++; if (pc !== 32'h0) $display("[TB] FAIL wrap_pc: got %h expected %h", pc, 32'h0); else passes++;
    checks++; if (finish !== 1'b1) $display("[TB] FAIL wrap_finish: got %b expected 1", finish); else passes++;
  endtask

  task automatic test_midrun_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 26'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 26'h0);
    checks++; if (pc !== 32'd8) $display("[TB] FAIL prereset_pc: got %h expected %h", pc, 32'd8); else passes++;
    #2 reset = 1'b0;
    #1;
    checks++; if (pc !== 32'h0) $display("[TB] FAIL async_pc: got %h expected %h", pc, 32'h0); else passes++;
    checks++; if (finish !== 1'b0) $display("[TB] FAIL async_finish: got %b expected 0", finish); else passes++;
    @(posedge clk);
    #1;
    checks++; if (pc !== 32'h0) $display("[TB] FAIL rstedge_pc: got %h expected %h", pc, 32'h0); else passes++;
    checks++; if (finish !== 1'b0) $display("[TB] FAIL rstedge_finish: got %b expected 0", finish); else passes++;
    @(negedge clk);
    reset = 1'b1; m_pc = 32'h0; m_finish = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 26'h0);
    checks++; if (pc !== 32'd4) $display("[TB] FAIL resume1_pc: got %h expected %h", pc, 32'd4); else passes++;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 26'h0);
    checks++; if (pc !== 32'd8) $display("[TB] FAIL resume2_pc: got %h expected %h", pc, 32'd8); else passes++;
  endtask

  task automatic test_random();
    logic        s, b, j;
    logic [31:0] off;
    logic [25:0] ja;
    for (int i = 0; i < 300; i++) begin
      s   = ($urandom_range(0, 3) != 0);
      b   = $urandom_range(0, 1) == 1;
      j   = ($urandom_range(0, 3) == 0);
      off = ($urandom_range(0, 1) == 1) ? $urandom : 32'($signed($urandom_range(0, 200)) - 100);
      ja  = 26'($urandom);
      drive(s, b, j, off, ja);
      checks++; if (pc !== m_pc) $display("[TB] FAIL rand_pc[%0d]: got %h expected %h", i, pc, m_pc); else passes++;
      checks++; if (finish !== m_finish) $display("[TB] FAIL rand_finish[%0d]: got %b expected %b", i, finish, m_finish); else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_jump_branch();
    test_priority();
    test_edges();
    test_midrun_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
